// File: rtl/cpu_pkg.sv
// Shared constants, opcodes and state encoding for the ALU issue/writeback unit.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int NREG    = 4;
    localparam int REG_AW  = 2;

    localparam logic [3:0] OP_PASSB      = 4'd0;
    localparam logic [3:0] OP_NOT        = 4'd1;
    localparam logic [3:0] OP_AND        = 4'd2;
    localparam logic [3:0] OP_OR         = 4'd3;
    localparam logic [3:0] OP_XOR        = 4'd4;
    localparam logic [3:0] OP_ADD        = 4'd5;
    localparam logic [3:0] OP_SUB        = 4'd6;
    localparam logic [3:0] OP_SHL        = 4'd7;
    localparam logic [3:0] OP_SHR        = 4'd8;
    localparam logic [3:0] OP_SRA        = 4'd9;
    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Widen the 7-bit immediate to a full data word, keeping its sign.
    function automatic logic [DATA_W-1:0] sext_imm7(input logic [6:0] imm);
        return {imm[6], imm};
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction issue handshake between an instruction source and the issue unit.
interface alu_issue_unit_if;
    import cpu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;

    modport master (
        output in_valid,
        output instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  instr,
        output in_ready
    );

endinterface

// File: rtl/RegFile4x8.sv
// Four 8-bit architectural registers: two operand read ports, one write port
// and an extra combinational read port used only for debug observation.
module RegFile4x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage, cleared asynchronously so an aborted write never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue and writeback stage in front of an external 8-bit ALU. Each accepted
// instruction walks IDLE -> READ -> EXEC -> WB, one instruction in flight.
module alu_issue_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    alu_issue_unit_if.slave     issue,
    output logic [3:0]          alu_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [DATA_W-1:0]   alu_c,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   result,
    output logic                flag_z,
    output logic                flag_n,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [3:0]         alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_n_q, flag_n_d;

    logic [3:0]         dec_op;
    logic               dec_use_imm;
    logic [REG_AW-1:0]  dec_rd;
    logic [REG_AW-1:0]  dec_rs;
    logic [6:0]         dec_imm7;

    logic               rf_we;
    logic [DATA_W-1:0]  rf_rdata_a;
    logic [DATA_W-1:0]  rf_rdata_b;

    assign dec_op      = instr_q[15:12];
    assign dec_use_imm = instr_q[11];
    assign dec_rd      = instr_q[10:9];
    assign dec_rs      = instr_q[8:7];
    assign dec_imm7    = instr_q[6:0];

    // Port A always reads the destination (two-address form), port B the source.
    RegFile4x8 u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (rf_we),
        .waddr    (dec_rd),
        .wdata    (res_q),
        .raddr_a  (dec_rd),
        .rdata_a  (rf_rdata_a),
        .raddr_b  (dec_rs),
        .rdata_b  (rf_rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Sequencer and datapath next-state; illegal ops still run through the ALU
    // but have their writeback replaced by an error pulse.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_sel_d = alu_sel_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        res_d     = res_q;
        result_d  = result_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        rf_we     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue.in_valid) begin
                    instr_d = issue.instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                alu_sel_d = dec_op;
                alu_a_d   = rf_rdata_a;
                alu_b_d   = dec_use_imm ? sext_imm7(dec_imm7) : rf_rdata_b;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = alu_c;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (dec_op <= OP_LAST_LEGAL) begin
                    rf_we    = 1'b1;
                    result_d = res_q;
                    flag_z_d = (res_q == '0);
                    flag_n_d = res_q[DATA_W-1];
                    done     = 1'b1;
                end else begin
                    err = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            alu_sel_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            res_q     <= '0;
            result_q  <= '0;
            flag_z_q  <= 1'b1;
            flag_n_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_sel_q <= alu_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            res_q     <= res_d;
            result_q  <= result_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
        end
    end

    assign issue.in_ready = (state_q == ST_IDLE);
    assign alu_sel        = alu_sel_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign result         = result_q;
    assign flag_z         = flag_z_q;
    assign flag_n         = flag_n_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU beside it and
// an architectural model of the register file and flags.
`timescale 1ns/1ps
module tb_alu_issue_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] alu_sel;
    logic [7:0] alu_a, alu_b, alu_c;
    logic       done, err;
    logic [7:0] result;
    logic       flag_z, flag_n;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    alu_issue_unit_if bus ();

    alu_issue_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .issue    (bus),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_c    (alu_c),
        .done     (done),
        .err      (err),
        .result   (result),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the neighbouring ALU; unknown selects produce zero.
    always_comb begin
        alu_c = 8'h00;
        case (alu_sel)
            4'd0: alu_c = alu_b;
            4'd1: alu_c = ~alu_a;
            4'd2: alu_c = alu_a & alu_b;
            4'd3: alu_c = alu_a | alu_b;
            4'd4: alu_c = alu_a ^ alu_b;
            4'd5: alu_c = alu_a + alu_b;
            4'd6: alu_c = alu_a - alu_b;
            4'd7: alu_c = alu_a << alu_b[2:0];
            4'd8: alu_c = alu_a >> alu_b[2:0];
            4'd9: alu_c = 8'($signed(alu_a) >>> alu_b[2:0]);
            default: alu_c = 8'h00;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int accept_cnt = 0;
    int done_cnt   = 0;
    logic prev_ready = 1'b0;

    // Accepts are seen as in_ready falling; done pulses counted once per cycle.
    always @(negedge clk) begin
        if (prev_ready === 1'b1 && bus.in_ready === 1'b0) accept_cnt++;
        prev_ready = bus.in_ready;
        if (done === 1'b1) done_cnt++;
    end

    int m_reg [4];
    int m_result;
    bit m_z, m_n;
    int e_sel, e_a, e_b;
    bit e_done, e_err;

    logic [3:0] o_sel;
    logic [7:0] o_a, o_b;
    logic       o_done, o_err, o_busy_ready, o_post_ready;

    function automatic int alu_ref(int op, int a, int b);
        int sh, sa;
        sh = b % 8;
        case (op)
            0: return b;
            1: return 255 - a;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a + b) % 256;
            6: return (a - b + 256) % 256;
            7: return (a * (1 << sh)) % 256;
            8: return a / (1 << sh);
            9: begin
                sa = (a >= 128) ? a - 256 : a;
                return (sa >>> sh) & 255;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_result = 0;
        m_z = 1'b1;
        m_n = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] w);
        int op, imm, rd, rs, r;
        op  = int'(w[15:12]);
        rd  = int'(w[10:9]);
        rs  = int'(w[8:7]);
        imm = int'(w[6:0]);
        e_sel = op;
        e_a   = m_reg[rd];
        e_b   = w[11] ? ((imm >= 64) ? imm + 128 : imm) : m_reg[rs];
        r     = alu_ref(op, e_a, e_b);
        if (op <= 9) begin
            m_reg[rd] = r;
            m_result  = r;
            m_z       = (r == 0);
            m_n       = (r >= 128);
            e_done    = 1'b1;
            e_err     = 1'b0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b1;
        end
    endtask

    // Drives one instruction through all four cycles and records what was seen.
    task automatic run_instr(input logic [15:0] w, input bit hold);
        int cnt;
        @(negedge clk);
        bus.instr    = w;
        bus.in_valid = 1'b1;
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt >= 20) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, cnt);
        end
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
        o_busy_ready = bus.in_ready;
        @(negedge clk);
        o_busy_ready = o_busy_ready | bus.in_ready;
        o_sel = alu_sel;
        o_a   = alu_a;
        o_b   = alu_b;
        @(negedge clk);
        o_busy_ready = o_busy_ready | bus.in_ready;
        o_done = done;
        o_err  = err;
        bus.in_valid = 1'b0;
        @(negedge clk);
        o_post_ready = bus.in_ready;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = 16'h0000;
        dbg_addr     = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        n_checks++;
        if ({alu_sel, alu_a, alu_b} !== 20'h0) begin n_fail++; $display("[TB] FAIL reset_alu_ports: got sel=%h a=%h b=%h, required 0/00/00", alu_sel, alu_a, alu_b); end
        n_checks++;
        if ({done, err} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_pulses: got done=%b err=%b, required 0 0", done, err); end
        n_checks++;
        if ({result, flag_z, flag_n} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL reset_flags: got result=%h z=%b n=%b, required 00 1 0", result, flag_z, flag_n); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            n_checks++;
            if (dbg_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_reg%0d: got %h, required 00", i, dbg_data); end
        end
    endtask

    task automatic test_load_imm();
        int d0;
        d0 = done_cnt;
        model_step(16'h0A05);
        run_instr(16'h0A05, 1'b0);
        dbg_addr = 2'd1;
        #1;
        n_checks++;
        if (dbg_data !== 8'h05 || 8'(m_reg[1]) !== 8'h05) begin n_fail++; $display("[TB] FAIL load_imm_r1: got %h, required 05", dbg_data); end
        n_checks++;
        if (o_done !== 1'b1 || done_cnt - d0 != 1) begin n_fail++; $display("[TB] FAIL load_imm_done: got done=%b pulses=%0d, required 1 and 1", o_done, done_cnt - d0); end
        n_checks++;
        if ({result, flag_z, flag_n} !== {8'h05, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL load_imm_flags: got result=%h z=%b n=%b, required 05 0 0", result, flag_z, flag_n); end
    endtask

    task automatic test_add_sub();
        model_step(16'h5A03);
        run_instr(16'h5A03, 1'b0);
        dbg_addr = 2'd1;
        #1;
        n_checks++;
        if (dbg_data !== 8'h08) begin n_fail++; $display("[TB] FAIL add_imm_r1: got %h, required 08", dbg_data); end
        model_step(16'h6A08);
        run_instr(16'h6A08, 1'b0);
        dbg_addr = 2'd1;
        #1;
        n_checks++;
        if ({dbg_data, flag_z, flag_n} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL sub_imm_r1: got r1=%h z=%b n=%b, required 00 1 0", dbg_data, flag_z, flag_n); end
    endtask

    task automatic test_sra();
        model_step(16'h0DFF);
        run_instr(16'h0DFF, 1'b0);
        dbg_addr = 2'd2;
        #1;
        n_checks++;
        if ({dbg_data, flag_n, flag_z} !== {8'hFF, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL ldi_neg_r2: got r2=%h n=%b z=%b, required FF 1 0", dbg_data, flag_n, flag_z); end
        n_checks++;
        if (o_b !== 8'hFF) begin n_fail++; $display("[TB] FAIL ldi_neg_sext: got alu_b=%h, required FF", o_b); end
        model_step(16'h9C01);
        run_instr(16'h9C01, 1'b0);
        dbg_addr = 2'd2;
        #1;
        n_checks++;
        if ({dbg_data, flag_n} !== {8'hFF, 1'b1}) begin n_fail++; $display("[TB] FAIL sra_r2: got r2=%h n=%b, required FF 1", dbg_data, flag_n); end
    endtask

    task automatic test_reg_reg();
        model_step(16'h0E10);
        run_instr(16'h0E10, 1'b0);
        model_step(16'h0A08);
        run_instr(16'h0A08, 1'b0);
        model_step(16'h5680);
        run_instr(16'h5680, 1'b0);
        n_checks++;
        if ({o_sel, o_a, o_b} !== {4'd5, 8'h10, 8'h08}) begin n_fail++; $display("[TB] FAIL rr_operands: got sel=%h a=%h b=%h, required 5 10 08", o_sel, o_a, o_b); end
        dbg_addr = 2'd3;
        #1;
        n_checks++;
        if (dbg_data !== 8'h18 || 8'(m_reg[3]) !== 8'h18) begin n_fail++; $display("[TB] FAIL rr_add_r3: got %h, required 18", dbg_data); end
    endtask

    task automatic test_illegal();
        int a0, d0;
        logic [7:0] res_before;
        logic       z_before, n_before;
        res_before = result;
        z_before   = flag_z;
        n_before   = flag_n;
        a0 = accept_cnt;
        d0 = done_cnt;
        model_step(16'hA000);
        run_instr(16'hA000, 1'b1);
        n_checks++;
        if (o_err !== 1'b1 || o_done !== 1'b0 || done_cnt != d0) begin n_fail++; $display("[TB] FAIL illegal_pulses: got err=%b done=%b extra_done=%0d, required 1 0 0", o_err, o_done, done_cnt - d0); end
        n_checks++;
        if (o_busy_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_busy_ready: got %b while busy, required 0", o_busy_ready); end
        n_checks++;
        if (accept_cnt - a0 != 1 || o_post_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_accepts: got %0d accepts ready_after=%b, required 1 and 1", accept_cnt - a0, o_post_ready); end
        n_checks++;
        if ({result, flag_z, flag_n} !== {res_before, z_before, n_before}) begin n_fail++; $display("[TB] FAIL illegal_flags: got %h %b %b, required %h %b %b", result, flag_z, flag_n, res_before, z_before, n_before); end
        dbg_addr = 2'd0;
        #1;
        n_checks++;
        if (dbg_data !== 8'(m_reg[0])) begin n_fail++; $display("[TB] FAIL illegal_r0: got %h, required %h", dbg_data, 8'(m_reg[0])); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.instr    = 16'h0BFF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        dbg_addr = 2'd1;
        #1;
        n_checks++;
        if ({bus.in_ready, alu_sel, alu_a, alu_b, done, err} !== {1'b1, 4'h0, 8'h00, 8'h00, 2'b00}) begin n_fail++; $display("[TB] FAIL midreset_ports: got rdy=%b sel=%h a=%h b=%h done=%b err=%b, required 1 0 00 00 0 0", bus.in_ready, alu_sel, alu_a, alu_b, done, err); end
        n_checks++;
        if ({result, flag_z, flag_n, dbg_data} !== {8'h00, 1'b1, 1'b0, 8'h00}) begin n_fail++; $display("[TB] FAIL midreset_state: got result=%h z=%b n=%b r1=%h, required 00 1 0 00", result, flag_z, flag_n, dbg_data); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || dbg_data !== 8'h00 || done_cnt < 0) begin n_fail++; $display("[TB] FAIL midreset_release: got rdy=%b r1=%h, required 1 00", bus.in_ready, dbg_data); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int op;
        for (int k = 0; k < 40; k++) begin
            op = ($urandom % 5 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            w  = {4'(op), 12'($urandom)};
            model_step(w);
            run_instr(w, 1'b0);
            n_checks++;
            if ({o_sel, o_a, o_b} !== {4'(e_sel), 8'(e_a), 8'(e_b)}) begin n_fail++; $display("[TB] FAIL rand_operands %h: got %h %h %h, required %h %h %h", w, o_sel, o_a, o_b, 4'(e_sel), 8'(e_a), 8'(e_b)); end
            n_checks++;
            if ({o_done, o_err} !== {e_done, e_err}) begin n_fail++; $display("[TB] FAIL rand_pulses %h: got done=%b err=%b, required %b %b", w, o_done, o_err, e_done, e_err); end
            n_checks++;
            if ({result, flag_z, flag_n} !== {8'(m_result), m_z, m_n}) begin n_fail++; $display("[TB] FAIL rand_flags %h: got %h %b %b, required %h %b %b", w, result, flag_z, flag_n, 8'(m_result), m_z, m_n); end
            for (int i = 0; i < 4; i++) begin
                dbg_addr = 2'(i);
                #1;
                n_checks++;
                if (dbg_data !== 8'(m_reg[i])) begin n_fail++; $display("[TB] FAIL rand_reg%0d %h: got %h, required %h", i, w, dbg_data, 8'(m_reg[i])); end
            end
        end
    endtask

    initial begin
        $display("[TB] starting alu_issue_unit bench");
        test_reset();
        test_load_imm();
        test_add_sub();
        test_sra();
        test_reg_reg();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a stimulus task stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue and writeback stage that sits directly upstream of the 8-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 4×8 register file, drives the ALU's `sel`/`A`/`B` inputs, captures the ALU result and writes it back, updating zero and negative flags. One instruction is in flight at a time, with a fixed 4-cycle issue-to-writeback sequence.

## Interface
- No parameters. Data width is 8, register count is 4, and instruction width is 16. All are fixed package constants.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  unit can accept an instruction; `in_ready` = (state == IDLE).
- `instr`  in  16  instruction word:
  - `[15:12]` op
  - `[11]` use_imm
  - `[10:9]` rd
  - `[8:7]` rs
  - `[6:0]` imm7
- `alu_sel`  out  4  registered opcode presented to the ALU.
- `alu_a`  out  8  registered operand A = R[rd].
- `alu_b`  out  8  registered operand B = use_imm ? sign-extended imm7 : R[rs].
- `alu_c`  in  8  combinational ALU result.
- `done`  out  1  one-cycle pulse in WB for a legal op.
- `err`  out  1  one-cycle pulse in WB for an illegal op (op 10–15).
- `result`  out  8  value written in the most recent WB; held until the next WB.
- `flag_z`, `flag_n`  out  1  zero flag (`result == 0`) and sign flag (`result[7]`); both updated only on legal WB.
- `dbg_addr`  in  2  debug read address.
- `dbg_data`  out  8  combinational R[`dbg_addr`].

## Operation
- States:
  - IDLE: on `in_valid && in_ready`, latch `instr` → READ.
  - READ: register `alu_sel`/`alu_a`/`alu_b` from the latched instruction and the register file → EXEC.
  - EXEC: capture `alu_c` into an internal result register → WB.
  - WB: if op ≤ 9, write the result register to R[rd], update `result`, `flag_z` and `flag_n`, and pulse `done`. If op ≥ 10, write nothing, leave the flags and `result` unchanged, and pulse `err`. Then → IDLE.
- The instruction format is two-address: the destination is always rd. Op 0 with use_imm=1 acts as load-immediate.
- Sign extension: `alu_b` = {imm7[6], imm7} when use_imm = 1.
- In register-register form, rd == rs is legal and reads the pre-write value.
- `alu_sel` for an illegal op is still driven with the raw op in READ/EXEC, because the ALU defaults harmlessly. Only the writeback is suppressed.
- `instr` is ignored outside IDLE. `in_valid` may stay high without side effects.
- No overflow or carry flag is kept.

## Timing
- Accept at edge t0. READ occupies cycle t0→t1, with ALU inputs valid after t1. EXEC captures the result at t2. WB occupies t2→t3: `done`/`err` are high in that cycle, and the register write lands at t3.
- `in_ready` returns high after t3.
- Throughput: one instruction per 4 cycles. Back-to-back instructions see the prior writeback, with no hazard logic.
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `alu_sel` = 0, `alu_a` = 0, `alu_b` = 0.
  - `done` = 0, `err` = 0, `result` = 0, `flag_z` = 1, `flag_n` = 0.
  - R0–R3 = 0.
- Reset asserted mid-instruction clears everything asynchronously. The in-flight instruction is discarded with no partial write.
- `dbg_data` reflects a write on the cycle after the WB edge.

## Structure
- Package `cpu_pkg` holds:
  - `DATA_W` = 8, `INSTR_W` = 16, `NREG` = 4.
  - Opcode localparams: `OP_PASSB` 0, `OP_NOT` 1, `OP_AND` 2, `OP_OR` 3, `OP_XOR` 4, `OP_ADD` 5, `OP_SUB` 6, `OP_SHL` 7, `OP_SHR` 8, `OP_SRA` 9, and `OP_LAST_LEGAL` = 9.
  - The state enum.
- One sub-module: `RegFile4x8`, a 2-read/1-write register file with async clear and a third combinational debug read port.
- The ALU is instantiated beside this block by the parent, not inside it.

## Test plan
- Reset, then `0x0A05` (load-immediate r1, 5) → after 4 cycles R1 = 0x05, `done` = 1 for one cycle, `flag_z` = 0, `flag_n` = 0. Check reset values before the first accept.
- `0x5A03` (ADD r1, #3), then `0x6A08` (SUB r1, #8) → R1 = 0x08, then 0x00 with `flag_z` = 1.
- `0x0DFF` (load-immediate r2, −1), then `0x9C01` (SRA r2, #1) → R2 = 0xFF both times, `flag_n` = 1.
- Register-register case: with R3 = 0x10 and R1 = 0x08, issue `0x5680` (ADD r3, r1) → R3 = 0x18. Check `alu_a` = 0x10 and `alu_b` = 0x08 at EXEC.
- `0xA000` (illegal op) → `err` pulses, `done` stays 0, R0 and the flags are unchanged. Hold `in_valid` high across all 4 cycles and confirm `in_ready` is low and only one instruction is accepted.
- Assert `reset_n` low during EXEC of `0x0BFF` → no write to R1. Outputs return to reset values immediately, and `in_ready` = 1 after release.
